// File: rtl/fpu_pkg.sv
// Shared FPU constants: default float format, divider pipeline depth, and the
// helper that sizes requester tags.
package fpu_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_EXP_WIDTH   = 8;
    localparam int DEF_MAN_WIDTH   = 23;
    localparam int DEF_BIAS        = 127;
    localparam int DEF_DIV_LATENCY = 4;
    localparam int DEF_N_REQ       = 2;

    // A single requester index still needs one bit of tag storage.
    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TAG_W = tag_w(DEF_N_REQ);

endpackage

// File: rtl/div.sv
// Pipelined float divider: quotient formed in one combinational stage, then carried
// through LATENCY registers; no enable, accepts a new operand pair every cycle.
module div #(
    parameter int WIDTH     = fpu_pkg::DEF_WIDTH,
    parameter int EXP_WIDTH = fpu_pkg::DEF_EXP_WIDTH,
    parameter int MAN_WIDTH = fpu_pkg::DEF_MAN_WIDTH,
    parameter int BIAS      = fpu_pkg::DEF_BIAS,
    parameter int LATENCY   = fpu_pkg::DEF_DIV_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot
);

    localparam logic [EXP_WIDTH-1:0] EMAX = {EXP_WIDTH{1'b1}};

    logic                       sa, sb, sgn;
    logic [EXP_WIDTH-1:0]       ea, eb, e_res;
    logic [MAN_WIDTH-1:0]       ma, mb, m_res;
    logic                       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [2*MAN_WIDTH+1:0]     num, den;
    logic [MAN_WIDTH+1:0]       q;
    int                         e_i;
    logic [WIDTH-1:0]           res;

    logic [LATENCY-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        sa     = a[WIDTH-1];
        sb     = b[WIDTH-1];
        ea     = a[WIDTH-2 -: EXP_WIDTH];
        eb     = b[WIDTH-2 -: EXP_WIDTH];
        ma     = a[MAN_WIDTH-1:0];
        mb     = b[MAN_WIDTH-1:0];
        sgn    = sa ^ sb;
        a_nan  = (ea == EMAX) && (ma != '0);
        b_nan  = (eb == EMAX) && (mb != '0);
        a_inf  = (ea == EMAX) && (ma == '0);
        b_inf  = (eb == EMAX) && (mb == '0);
        // Subnormals are flushed to zero on input.
        a_zero = (ea == '0);
        b_zero = (eb == '0);

        // 1.ma / 1.mb lies in (0.5, 2); the scaled quotient keeps MAN_WIDTH+2 bits.
        num    = {1'b1, ma, {(MAN_WIDTH+1){1'b0}}};
        den    = {{(MAN_WIDTH+1){1'b0}}, 1'b1, mb};
        q      = (MAN_WIDTH+2)'(num / den);
        e_i    = int'(ea) - int'(eb) + BIAS - (q[MAN_WIDTH+1] ? 0 : 1);
        m_res  = q[MAN_WIDTH+1] ? q[MAN_WIDTH:1] : q[MAN_WIDTH-1:0];
        e_res  = '0;

        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            res = {1'b0, EMAX, 1'b1, {(MAN_WIDTH-1){1'b0}}};
        end else if (a_inf || b_zero) begin
            res = {sgn, EMAX, {MAN_WIDTH{1'b0}}};
        end else if (a_zero || b_inf) begin
            res = {sgn, {EXP_WIDTH{1'b0}}, {MAN_WIDTH{1'b0}}};
        end else if (e_i >= int'(EMAX)) begin
            res = {sgn, EMAX, {MAN_WIDTH{1'b0}}};
        end else if (e_i <= 0) begin
            res = {sgn, {EXP_WIDTH{1'b0}}, {MAN_WIDTH{1'b0}}};
        end else begin
            e_res = EXP_WIDTH'(e_i);
            res   = {sgn, e_res, m_res};
        end

        pipe_d[0] = res;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign quot = pipe_q[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer;
// pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
    parameter int N = fpu_pkg::DEF_N_REQ
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PW = (N <= 2) ? 1 : $clog2(N);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;
    int            nxt;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        nxt   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!rst && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt      = (idx + 1 == N) ? 0 : idx + 1;
            end
        end
        ptr_d = (adv && found) ? PW'(nxt) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_div_arbiter.sv
// Shares one pipelined divider between N_REQ requesters via round-robin grant;
// quotient strobes back 1+DIV_LATENCY edges after the request cycle, no result backpressure.
module fpu_div_arbiter #(
    parameter int WIDTH       = fpu_pkg::DEF_WIDTH,
    parameter int EXP_WIDTH   = fpu_pkg::DEF_EXP_WIDTH,
    parameter int MAN_WIDTH   = fpu_pkg::DEF_MAN_WIDTH,
    parameter int BIAS        = fpu_pkg::DEF_BIAS,
    parameter int N_REQ       = fpu_pkg::DEF_N_REQ,
    parameter int DIV_LATENCY = fpu_pkg::DEF_DIV_LATENCY
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ*WIDTH-1:0]            req_a,
    input  logic [N_REQ*WIDTH-1:0]            req_b,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [N_REQ-1:0]                  res_valid,
    output logic [WIDTH-1:0]                  res_data,
    output logic [$clog2(DIV_LATENCY+2)-1:0]  in_flight,
    output logic                              busy
);

    import fpu_pkg::*;

    localparam int TAG_W = tag_w(N_REQ);
    localparam int IFW   = $clog2(DIV_LATENCY+2);

    logic [N_REQ-1:0] gnt;
    logic             accept;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [TAG_W-1:0] sel_tag;

    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;

    logic [DIV_LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
    logic [DIV_LATENCY-1:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;
    logic [IFW-1:0]                    in_flight_q, in_flight_d;

    logic             tail_vld;
    logic [TAG_W-1:0] tail_tag;
    logic [WIDTH-1:0] quot;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .adv (accept),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);
    assign tail_vld  = vld_pipe_q[DIV_LATENCY-1];
    assign tail_tag  = tag_pipe_q[DIV_LATENCY-1];

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_tag = TAG_W'(i);
            end
        end

        // Operands hold when idle so the divider input stays quiet.
        op_valid_d = accept;
        op_a_d     = accept ? sel_a   : op_a_q;
        op_b_d     = accept ? sel_b   : op_b_q;
        op_tag_d   = accept ? sel_tag : op_tag_q;

        vld_pipe_d[0] = op_valid_q;
        tag_pipe_d[0] = op_tag_q;
        for (int i = 1; i < DIV_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end

        in_flight_d = in_flight_q;
        if (accept && !tail_vld) begin
            in_flight_d = in_flight_q + IFW'(1);
        end else if (!accept && tail_vld) begin
            in_flight_d = in_flight_q - IFW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_valid_q  <= 1'b0;
            op_tag_q    <= '0;
            vld_pipe_q  <= '0;
            tag_pipe_q  <= '0;
            in_flight_q <= '0;
        end else begin
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_valid_q  <= op_valid_d;
            op_tag_q    <= op_tag_d;
            vld_pipe_q  <= vld_pipe_d;
            tag_pipe_q  <= tag_pipe_d;
            in_flight_q <= in_flight_d;
        end
    end

    div #(
        .WIDTH     (WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH),
        .BIAS      (BIAS),
        .LATENCY   (DIV_LATENCY)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .a    (op_a_q),
        .b    (op_b_q),
        .quot (quot)
    );

    always_comb begin
        res_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            res_valid[i] = tail_vld && (tail_tag == TAG_W'(i));
        end
    end

    assign res_data  = quot;
    assign in_flight = in_flight_q;
    assign busy      = (in_flight_q != '0);

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Randomised and directed bench for fpu_div_arbiter against a queue-based model.
module tb_fpu_div_arbiter;

    localparam int W   = 32;
    localparam int N   = 2;
    localparam int L   = 4;
    localparam int IFW = $clog2(L+2);

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready, res_valid;
    logic [W-1:0]     res_data;
    logic [IFW-1:0]   in_flight;
    logic             busy;

    always #5 clk = ~clk;

    fpu_div_arbiter #(
        .WIDTH(W), .EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(127), .N_REQ(N), .DIV_LATENCY(L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .in_flight (in_flight),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int ptr_m  = 0;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] q;
    } pend_t;
    pend_t pend[$];

    logic [N-1:0] obs_rdy, exp_rdy, obs_rv, exp_rv;
    logic [31:0]  obs_rd, exp_rd;
    int           obs_if, exp_if;
    logic         obs_busy;

    // Divisors are always powers of two, so the quotient only shifts the exponent.
    function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
        int e;
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        return {a[31] ^ b[31], e[7:0], a[22:0]};
    endfunction

    function automatic logic [31:0] rand_a();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(190, 60)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_b();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'd0};
    endfunction

    // One clock cycle: capture outputs, drive requests, capture grant, advance to next negedge.
    task automatic cycle(input logic [N-1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
        pend_t p;
        obs_rv   = res_valid;
        obs_rd   = res_data;
        obs_if   = int'(in_flight);
        obs_busy = busy;
        exp_rv   = '0;
        exp_rd   = '0;
        exp_if   = pend.size();
        if (pend.size() > 0 && pend[0].due == edges) begin
            exp_rv[pend[0].idx] = 1'b1;
            exp_rd = pend[0].q;
            void'(pend.pop_front());
        end
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        #1;
        obs_rdy = req_ready;
        exp_rdy = '0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (v[i] && exp_rdy == '0) begin
                exp_rdy[i] = 1'b1;
                p.due = edges + 1 + L;
                p.idx = i;
                p.q   = ref_quot(i == 0 ? a0 : a1, i == 0 ? b0 : b1);
                pend.push_back(p);
                ptr_m = (i + 1) % N;
            end
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        req_a = {32'h40000000, 32'h40000000};
        req_b = {32'h3F800000, 32'h3F800000};
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
        checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL reset_res_valid got %b want 00", res_valid); end
        checks++; if (in_flight !== '0) begin errors++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        int strobe_at = -1;
        int max_if = 0;
        logic [31:0] got = '0;
        for (int j = 0; j < L + 4; j++) begin
            cycle(j == 0 ? 2'b01 : 2'b00, 32'h40C00000, 32'h40000000, 32'h0, 32'h0);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL single_grant got %b want %b", obs_rdy, exp_rdy); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL single_res_valid got %b want %b", obs_rv, exp_rv); end
            checks++; if (obs_if !== exp_if) begin errors++; $display("FAIL single_in_flight got %0d want %0d", obs_if, exp_if); end
            if (obs_if > max_if) max_if = obs_if;
            if (obs_rv[0] && strobe_at < 0) begin strobe_at = j; got = obs_rd; end
        end
        checks++; if (strobe_at != L + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", strobe_at, L + 1); end
        checks++; if (got !== 32'h40400000) begin errors++; $display("FAIL single_data got %h want 40400000", got); end
        checks++; if (max_if != 1) begin errors++; $display("FAIL single_max_in_flight got %0d want 1", max_if); end
        checks++; if (obs_if != 0) begin errors++; $display("FAIL single_drained got %0d want 0", obs_if); end
    endtask

    task automatic test_contention();
        int max_if = 0;
        for (int j = 0; j < 2 * L + 6 + L + 2; j++) begin
            cycle(j < 2 * L + 6 ? 2'b11 : 2'b00, 32'h3F800000, 32'h40000000, 32'hC1000000, 32'h40800000);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL cont_grant got %b want %b", obs_rdy, exp_rdy); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL cont_res_valid got %b want %b", obs_rv, exp_rv); end
            checks++; if (obs_if !== exp_if) begin errors++; $display("FAIL cont_in_flight got %0d want %0d", obs_if, exp_if); end
            if (obs_rv[0]) begin checks++; if (obs_rd !== 32'h3F000000) begin errors++; $display("FAIL cont_data0 got %h want 3f000000", obs_rd); end end
            if (obs_rv[1]) begin checks++; if (obs_rd !== 32'hC0000000) begin errors++; $display("FAIL cont_data1 got %h want c0000000", obs_rd); end end
            if (obs_if > max_if) max_if = obs_if;
        end
        checks++; if (max_if != L + 1) begin errors++; $display("FAIL cont_max_in_flight got %0d want %0d", max_if, L + 1); end
    endtask

    task automatic test_fairness();
        for (int j = 0; j < 5 + L + 2; j++) begin
            cycle(j < 3 ? 2'b10 : (j < 5 ? 2'b11 : 2'b00), rand_a(), rand_b(), rand_a(), rand_b());
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL fair_grant got %b want %b", obs_rdy, exp_rdy); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL fair_res_valid got %b want %b", obs_rv, exp_rv); end
            if (exp_rv != '0) begin checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL fair_data got %h want %h", obs_rd, exp_rd); end end
            if (j == 3) begin checks++; if (obs_rdy !== 2'b01) begin errors++; $display("FAIL fair_first_contended got %b want 01", obs_rdy); end end
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        logic [7:0] e8;
        for (int j = 0; j < 8 + L + 3; j++) begin
            e8 = 8'(128 + j);
            cycle(j < 8 ? 2'b10 : 2'b00, 32'h0, 32'h0, {1'b0, e8, 23'd0}, 32'h40000000);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_grant got %b want %b", obs_rdy, exp_rdy); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL b2b_res_valid got %b want %b", obs_rv, exp_rv); end
            if (obs_rv[1]) begin
                e8 = 8'(127 + seen);
                checks++; if (obs_rd !== {1'b0, e8, 23'd0}) begin errors++; $display("FAIL b2b_data got %h want %h", obs_rd, {1'b0, e8, 23'd0}); end
                checks++; if (j != L + 1 + seen) begin errors++; $display("FAIL b2b_strobe_cycle got %0d want %0d", j, L + 1 + seen); end
                seen++;
            end
        end
        checks++; if (seen != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", seen); end
    endtask

    task automatic test_reset_midflight();
        for (int j = 0; j < 3; j++) begin
            cycle(2'b01, rand_a(), rand_b(), 32'h0, 32'h0);
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rmid_grant got %b want %b", obs_rdy, exp_rdy); end
        end
        req_valid = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rmid_ready got %b want 00", req_ready); end
        checks++; if (res_valid !== 2'b00) begin errors++; $display("FAIL rmid_res_valid got %b want 00", res_valid); end
        checks++; if (in_flight !== '0) begin errors++; $display("FAIL rmid_in_flight got %0d want 0", in_flight); end
        @(posedge clk);
        edges++;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        pend.delete();
        ptr_m = 0;
        for (int j = 0; j < L + 4; j++) begin
            cycle(j == L + 3 ? 2'b11 : 2'b00, rand_a(), rand_b(), rand_a(), rand_b());
            checks++; if (obs_rv !== 2'b00) begin errors++; $display("FAIL rmid_stale_strobe got %b want 00", obs_rv); end
            checks++; if (obs_if !== exp_if) begin errors++; $display("FAIL rmid_in_flight_after got %0d want %0d", obs_if, exp_if); end
        end
        checks++; if (obs_rdy !== 2'b01) begin errors++; $display("FAIL rmid_first_grant got %b want 01", obs_rdy); end
        for (int j = 0; j < L + 2; j++) begin
            cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL rmid_res_valid2 got %b want %b", obs_rv, exp_rv); end
            if (exp_rv != '0) begin checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rmid_data got %h want %h", obs_rd, exp_rd); end end
        end
    endtask

    task automatic test_idle();
        for (int j = 0; j < 20; j++) begin
            cycle(2'b00, rand_a(), rand_b(), rand_a(), rand_b());
            checks++; if (obs_rdy !== 2'b00) begin errors++; $display("FAIL idle_ready got %b want 00", obs_rdy); end
            checks++; if (obs_rv !== 2'b00) begin errors++; $display("FAIL idle_res_valid got %b want 00", obs_rv); end
            checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", obs_busy); end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 120 + L + 2; j++) begin
            cycle(j < 120 ? 2'($urandom_range(3, 0)) : 2'b00, rand_a(), rand_b(), rand_a(), rand_b());
            checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rand_grant got %b want %b", obs_rdy, exp_rdy); end
            checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL rand_res_valid got %b want %b", obs_rv, exp_rv); end
            checks++; if (obs_if !== exp_if) begin errors++; $display("FAIL rand_in_flight got %0d want %0d", obs_if, exp_if); end
            checks++; if (obs_busy !== (exp_if != 0)) begin errors++; $display("FAIL rand_busy got %b want %b", obs_busy, exp_if != 0); end
            if (exp_rv != '0) begin checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rand_data got %h want %h", obs_rd, exp_rd); end end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_back_to_back();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
